// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT butterfly scheduler: default widths,
// bit positions inside the butterfly command tag, and the scheduler FSM states.
package fft_pkg;

    localparam int FFT_DATA_WIDTH = 16;
    localparam int FFT_CMD_WIDTH  = 3;

    // Bit positions inside bf_m
    localparam int BFM_VALID = 0;
    localparam int BFM_FIRST = 1;
    localparam int BFM_LAST  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_bf_scheduler_if.sv
// Bus between the scheduler and its surroundings (data RAM, twiddle ROM and
// butterfly pipeline). The master modport is the scheduler side.
//
// Handshake: start is a one-cycle request that is only accepted while the
// scheduler is idle; there is no ready signal, the requester watches busy
// and done instead. Every read strobe has a fixed one-cycle data latency and
// the scheduler never stalls, so rd_en/wr_en are plain strobes with no
// back-pressure.
interface fft_bf_scheduler_if
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int CMD_WIDTH  = FFT_CMD_WIDTH,
    parameter int LOG2N      = 3
);

    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [LOG2N-1:0]        rd_addr_a;
    logic [LOG2N-1:0]        rd_addr_b;
    logic [2*DATA_WIDTH-1:0] rd_data_a;
    logic [2*DATA_WIDTH-1:0] rd_data_b;
    logic [LOG2N-2:0]        tw_addr;
    logic [2*DATA_WIDTH-1:0] tw_data;
    logic [2*DATA_WIDTH-1:0] bf_a;
    logic [2*DATA_WIDTH-1:0] bf_b;
    logic [2*DATA_WIDTH-1:0] bf_w;
    logic [CMD_WIDTH-1:0]    bf_m;
    logic                    wr_en;
    logic [LOG2N-1:0]        wr_addr_a;
    logic [LOG2N-1:0]        wr_addr_b;

    modport master (
        input  start, rd_data_a, rd_data_b, tw_data,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_a, bf_b, bf_w, bf_m, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, rd_data_a, rd_data_b, tw_data,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_a, bf_b, bf_w, bf_m, wr_en, wr_addr_a, wr_addr_b
    );

endinterface

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear. Used to carry the
// write strobe and write addresses alongside the butterfly pipeline.
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    // Shift one stage per clock; clear wipes every stage so nothing in flight survives
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_bf_scheduler.sv
// Operand issuer for an in-place radix-2 DIT FFT (input stored bit-reversed).
// Walks LOG2N stages of N/2 butterflies, one per clock, issuing RAM and
// twiddle reads, a registered command tag that lines up with the read data,
// and write-back addresses delayed to line up with the butterfly outputs.
// Between stages it drains long enough for the last write of a stage to
// commit before the next stage reads.
module fft_bf_scheduler
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int CMD_WIDTH  = FFT_CMD_WIDTH,
    parameter int LOG2N      = 3,
    parameter int BF_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    fft_bf_scheduler_if.master  bus,
    output state_t              dbg_state
);

    localparam int KW = LOG2N - 1;                  // butterfly index width (N/2 per stage)
    localparam int SW = $clog2(LOG2N);              // stage index width
    localparam int DCW = $clog2(BF_LATENCY + 2);    // drain counter width
    localparam int DLW = 1 + 2 * LOG2N;             // {wr_en, wr_addr_a, wr_addr_b}

    localparam logic [KW-1:0]  K_LAST = KW'((1 << KW) - 1);
    localparam logic [SW-1:0]  S_LAST = SW'(LOG2N - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(BF_LATENCY);

    state_t               state, state_n;
    logic [KW-1:0]        k, k_n;
    logic [SW-1:0]        s, s_n;
    logic [DCW-1:0]       dcnt, dcnt_n;
    logic [CMD_WIDTH-1:0] cmd_n, cmd_q;

    logic [LOG2N-1:0]     kk, half, j, addr_a, addr_b;
    logic [DLW-1:0]       dl_q;

    assign dbg_state = state;

    // State, butterfly index, stage index, drain counter and command tag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            dcnt  <= '0;
            cmd_q <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            s     <= s_n;
            dcnt  <= dcnt_n;
            cmd_q <= cmd_n;
        end
    end

    // Next-state logic plus the status and read strobes that follow the state
    always_comb begin
        state_n   = state;
        k_n       = k;
        s_n       = s;
        dcnt_n    = dcnt;
        cmd_n     = '0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ISSUE;
                    k_n     = '0;
                    s_n     = '0;
                end
            end
            ISSUE: begin
                bus.busy          = 1'b1;
                bus.rd_en         = 1'b1;
                cmd_n[BFM_VALID]  = 1'b1;
                cmd_n[BFM_FIRST]  = (k == '0);
                cmd_n[BFM_LAST]   = (s == S_LAST) && (k == K_LAST);
                if (k == K_LAST) begin
                    state_n = DRAIN;
                    k_n     = '0;
                    dcnt_n  = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (dcnt == D_LAST) begin
                    if (s == S_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        s_n     = s + 1'b1;
                    end
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand addresses: group base (k above the stage bit, shifted up) plus offset j
    always_comb begin
        kk     = {1'b0, k};
        half   = LOG2N'(1) << s;
        j      = kk & (half - 1'b1);
        addr_a = ((kk >> s) << (int'(s) + 1)) | j;
        addr_b = addr_a | half;
    end

    // Read and twiddle addresses are driven only while issuing, zero otherwise
    always_comb begin
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.tw_addr   = '0;
        if (state == ISSUE) begin
            bus.rd_addr_a = addr_a;
            bus.rd_addr_b = addr_b;
            bus.tw_addr   = (LOG2N-1)'(j << (LOG2N - 1 - int'(s)));
        end
    end

    // One cycle for the RAM read plus the butterfly latency
    fft_delay_line #(
        .WIDTH (DLW),
        .DEPTH (1 + BF_LATENCY)
    ) u_wr_delay (
        .clk (clk),
        .clr (rst),
        .d   ({bus.rd_en, bus.rd_addr_a, bus.rd_addr_b}),
        .q   (dl_q)
    );

    assign bus.wr_en     = dl_q[DLW-1];
    assign bus.wr_addr_a = dl_q[2*LOG2N-1:LOG2N];
    assign bus.wr_addr_b = dl_q[LOG2N-1:0];

    // Operands and twiddle pass straight through; the RAM/ROM already register them
    assign bus.bf_a = bus.rd_data_a[2*DATA_WIDTH-1:0];
    assign bus.bf_b = bus.rd_data_b[2*DATA_WIDTH-1:0];
    assign bus.bf_w = bus.tw_data[2*DATA_WIDTH-1:0];
    assign bus.bf_m = cmd_q;

endmodule
